cache_line_filler: RTL and testbench

Write-side controller for the cache's line storage arrays. On a miss, it optionally writes back the dirty victim line to physical memory as a 4-beat burst. It then fetches the requested line as a 4-beat burst, assembles the 256-bit line, and loads the data, tag, valid and dirty arrays in one cycle. It sits between the cache control FSM (requester) and the physical-memory port, and drives the arrays' `read`/`load`/`rindex`/`windex`/`datain` ports.

---
 rtl/cache_fill_pkg.sv | 8 +
 rtl/beat_buffer.sv | 20 ++
 rtl/cache_line_filler.sv | 93 +++++++++
 tb/tb_cache_line_filler.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_pkg.sv
// cache_fill_pkg: shared state encoding and line geometry for the cache line filler
package cache_fill_pkg;
  typedef enum logic [2:0] {IDLE, WB_CAPTURE, WB_BURST, FILL_BURST, LOAD, DONE} state_t;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS = 4;
  localparam int OFFSET_W = 5;
endpackage

// File: rtl/beat_buffer.sv
// beat_buffer: 256-bit line register with full-line load and per-beat write/read
module beat_buffer import cache_fill_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [LINE_W-1:0] load_data,
  input  logic              wr_en,
  input  logic [1:0]        wr_slot,
  input  logic [BEAT_W-1:0] wr_data,
  input  logic [1:0]        rd_slot,
  output logic [BEAT_W-1:0] rd_data,
  output logic [LINE_W-1:0] line
);
  // full-line capture wins over a beat write; reset clears the line
  always_ff @(posedge clk)
    if (rst) line <= '0;
    else if (load_en) line <= load_data;
    else if (wr_en) line[wr_slot*BEAT_W +: BEAT_W] <= wr_data;
  assign rd_data = line[rd_slot*BEAT_W +: BEAT_W];
endmodule

// File: rtl/cache_line_filler.sv
// cache_line_filler: victim writeback and line fill bursts feeding the cache arrays
module cache_line_filler import cache_fill_pkg::*; #(
  parameter int s_index = 3,
  parameter int s_tag = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               miss_req,
  input  logic [31:0]        miss_addr,
  input  logic               victim_dirty,
  input  logic [s_tag-1:0]   victim_tag,
  output logic               fill_done,
  output logic               arr_read,
  output logic [s_index-1:0] arr_rindex,
  input  logic [LINE_W-1:0]  arr_dataout,
  output logic               line_load,
  output logic [s_index-1:0] arr_windex,
  output logic [LINE_W-1:0]  arr_datain,
  output logic [s_tag-1:0]   tag_datain,
  output logic               valid_datain,
  output logic               dirty_datain,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic [31:0]        pmem_address,
  output logic [BEAT_W-1:0]  pmem_wdata,
  input  logic [BEAT_W-1:0]  pmem_rdata,
  input  logic               pmem_resp
);
  state_t state, next_state;
  logic [1:0] cnt;
  logic [s_tag-1:0] tag, vtag;
  logic [s_index-1:0] index;
  logic [LINE_W-1:0] line;
  logic [BEAT_W-1:0] beat;
  logic in_burst, last, unused_offset;
  assign unused_offset = ^miss_addr[OFFSET_W-1:0];
  assign in_burst = state == WB_BURST || state == FILL_BURST;
  assign last = pmem_resp && cnt == 2'd3;
  // state, beat counter and request latches
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      tag <= '0;
      vtag <= '0;
      index <= '0;
    end else begin
      state <= next_state;
      if (in_burst && pmem_resp) cnt <= cnt + 2'd1;
      if (state == IDLE && miss_req) begin
        {tag, index} <= miss_addr[31:OFFSET_W];
        vtag <= victim_tag;
      end
    end
  // next-state: optional writeback, fill, one-cycle load, one-cycle done
  always_comb begin
    next_state = state;
    case (state)
      IDLE:       next_state = miss_req ? (victim_dirty ? WB_CAPTURE : FILL_BURST) : IDLE;
      WB_CAPTURE: next_state = WB_BURST;
      WB_BURST:   next_state = last ? FILL_BURST : WB_BURST;
      FILL_BURST: next_state = last ? LOAD : FILL_BURST;
      LOAD:       next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end
  beat_buffer u_buf (
    .clk(clk),
    .rst(rst),
    .load_en(state == WB_CAPTURE),
    .load_data(arr_dataout),
    .wr_en(state == FILL_BURST && pmem_resp),
    .wr_slot(cnt),
    .wr_data(pmem_rdata),
    .rd_slot(cnt),
    .rd_data(beat),
    .line(line)
  );
  assign arr_read = state == WB_CAPTURE;
  assign arr_rindex = arr_read ? index : '0;
  assign line_load = state == LOAD;
  assign arr_windex = line_load ? index : '0;
  assign arr_datain = line_load ? line : '0;
  assign tag_datain = line_load ? tag : '0;
  assign valid_datain = 1'b1;
  assign dirty_datain = 1'b0;
  assign pmem_write = state == WB_BURST;
  assign pmem_read = state == FILL_BURST;
  assign pmem_address = pmem_write ? {vtag, index, {OFFSET_W{1'b0}}} :
                        pmem_read ? {tag, index, {OFFSET_W{1'b0}}} : '0;
  assign pmem_wdata = pmem_write ? beat : '0;
  assign fill_done = state == DONE;
endmodule

// File: tb/tb_cache_line_filler.sv
// tb_cache_line_filler: randomized fills checked against a transaction-level model
module tb_cache_line_filler;
  logic clk = 0, rst = 1, miss_req = 0, victim_dirty = 0, pmem_resp = 0;
  logic [31:0] miss_addr = 0;
  logic [23:0] victim_tag = 0;
  logic [63:0] pmem_rdata = 0;
  logic [255:0] arr_dataout, fill_line = 0;
  logic fill_done, arr_read, line_load, valid_datain, dirty_datain, pmem_read, pmem_write;
  logic [2:0] arr_rindex, arr_windex;
  logic [255:0] arr_datain;
  logic [23:0] tag_datain;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic [255:0] arr [8];
  logic [255:0] exp_arr [8];
  logic seed_en = 0;
  logic [2:0] seed_idx = 0;
  logic [255:0] seed_val = 0;
  int total = 0, bad = 0, gap = 0;
  bit stray = 0;
  logic [31:0] rd_aq[$], wr_aq[$];
  logic [63:0] wr_q[$];
  int ll_c, fd_c, rd_cyc, wr_cyc, both_hi;
  logic [2:0] ld_idx;
  logic [23:0] ld_tag;
  logic [255:0] ld_line;

  cache_line_filler dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag), .fill_done(fill_done),
    .arr_read(arr_read), .arr_rindex(arr_rindex), .arr_dataout(arr_dataout),
    .line_load(line_load), .arr_windex(arr_windex), .arr_datain(arr_datain),
    .tag_datain(tag_datain), .valid_datain(valid_datain), .dirty_datain(dirty_datain),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  // external data array: combinational read, loaded by the filler or seeded by the bench
  assign arr_dataout = arr[arr_rindex];
  always @(posedge clk) begin
    if (seed_en) arr[seed_idx] <= seed_val;
    if (line_load) arr[arr_windex] <= arr_datain;
  end

  // memory responder: one resp per beat after `gap` idle cycles; optional stray pulses when idle
  initial begin
    int w, rb;
    w = 0;
    rb = 0;
    forever begin
      @(negedge clk);
      pmem_resp = 0;
      if (rst || !pmem_read) rb = 0;
      if (rst || !(pmem_read || pmem_write)) begin
        w = 0;
        pmem_resp = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      end else if (w < gap) w++;
      else begin
        w = 0;
        pmem_resp = 1;
        if (pmem_read) begin
          pmem_rdata = fill_line[rb*64 +: 64];
          rb = (rb + 1) % 4;
          rd_aq.push_back(pmem_address);
        end else begin
          wr_q.push_back(pmem_wdata);
          wr_aq.push_back(pmem_address);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [255:0] rnd_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int n_eq(logic [31:0] q[$], logic [31:0] e);
    int n = 0;
    foreach (q[i]) n += int'(q[i] === e);
    return n;
  endfunction

  function automatic logic [255:0] pack_wr();
    logic [255:0] r = '0;
    foreach (wr_q[i]) if (i < 4) r[i*64 +: 64] = wr_q[i];
    return r;
  endfunction

  function automatic logic [191:0] t_obs(logic [31:0] ra, logic [31:0] wa);
    return {32'(ll_c), 32'(fd_c), 32'(rd_cyc), 32'(wr_cyc), 32'(both_hi),
            8'(n_eq(rd_aq, ra)), 8'(rd_aq.size()), 8'(n_eq(wr_aq, wa)), 8'(wr_aq.size())};
  endfunction

  // each beat costs gap+1 cycles; a dirty miss adds a capture cycle and a write burst
  function automatic logic [191:0] t_exp(logic d, int g);
    int b, fd;
    b = 4 * (g + 1);
    fd = (d ? b + 1 : 0) + b + 2;
    return {32'(fd - 1), 32'(fd), 32'(b), d ? 32'(b) : 32'd0, 32'd0,
            8'd4, 8'd4, d ? 8'd4 : 8'd0, d ? 8'd4 : 8'd0};
  endfunction

  function automatic logic [538:0] d_obs();
    return {ld_idx, ld_tag, ld_line, pack_wr()};
  endfunction

  function automatic logic [538:0] d_exp(logic [31:0] a, logic d, logic [255:0] fl);
    return {a[7:5], a[31:8], fl, d ? exp_arr[a[7:5]] : 256'd0};
  endfunction

  function automatic logic [388:0] outs();
    return {arr_read, arr_rindex, line_load, arr_windex, arr_datain, tag_datain, dirty_datain,
            pmem_read, pmem_write, pmem_address, pmem_wdata, fill_done, valid_datain};
  endfunction

  task automatic seed(input logic [2:0] idx, input logic [255:0] val);
    @(negedge clk);
    seed_en = 1;
    seed_idx = idx;
    seed_val = val;
    exp_arr[idx] = val;
    @(negedge clk);
    seed_en = 0;
  endtask

  task automatic run_fill(input logic [31:0] a, input logic d, input logic [23:0] vt,
                          input logic [255:0] fl, input int g, input bit hold);
    fill_line = fl;
    gap = g;
    rd_aq.delete();
    wr_aq.delete();
    wr_q.delete();
    ll_c = -1; fd_c = -1; rd_cyc = 0; wr_cyc = 0; both_hi = 0;
    ld_idx = 0; ld_tag = 0; ld_line = 0;
    @(negedge clk);
    miss_req = 1;
    miss_addr = a;
    victim_dirty = d;
    victim_tag = vt;
    for (int c = 1; c <= 300 && fd_c < 0; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) begin
        miss_req = 0;
        miss_addr = $urandom;
        victim_dirty = 1'($urandom);
        victim_tag = 24'($urandom);
      end
      rd_cyc += int'(pmem_read);
      wr_cyc += int'(pmem_write);
      both_hi += int'(pmem_read && pmem_write);
      if (line_load) begin
        ll_c = c;
        ld_line = arr_datain;
        ld_idx = arr_windex;
        ld_tag = tag_datain;
      end
      if (fill_done) fd_c = c;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 8; i++) seed(3'(i), rnd_line());
    if (outs() !== 389'd1) begin bad++; $display("FAIL reset_outputs got=%h want=%h", outs(), 389'd1); end
    total++;
    rst = 0;
    @(negedge clk);
    if (outs() !== 389'd1) begin bad++; $display("FAIL idle_outputs got=%h want=%h", outs(), 389'd1); end
    total++;
  endtask

  task automatic test_clean();
    logic [31:0] a;
    logic [255:0] fl;
    for (int n = 0; n < 4; n++) begin
      a = n == 0 ? 32'h0000_1A40 : $urandom;
      fl = n == 0 ? {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}} : rnd_line();
      run_fill(a, 0, 24'($urandom), fl, 0, 0);
      if (t_obs({a[31:5], 5'b0}, 0) !== t_exp(0, 0)) begin
        bad++; $display("FAIL clean_timing n=%0d got=%h want=%h", n, t_obs({a[31:5], 5'b0}, 0), t_exp(0, 0));
      end
      if (d_obs() !== d_exp(a, 0, fl)) begin
        bad++; $display("FAIL clean_data n=%0d got=%h want=%h", n, d_obs(), d_exp(a, 0, fl));
      end
      total += 2;
      exp_arr[a[7:5]] = fl;
    end
  endtask

  task automatic test_dirty();
    logic [31:0] a = 32'h1234_565F;
    logic [23:0] vt = 24'h00ABCD;
    seed(3'd2, rnd_line());
    run_fill(a, 1, vt, rnd_line(), 0, 0);
    if (t_obs(32'h1234_5640, 32'h00AB_CD40) !== t_exp(1, 0)) begin
      bad++; $display("FAIL dirty_timing got=%h want=%h", t_obs(32'h1234_5640, 32'h00AB_CD40), t_exp(1, 0));
    end
    if (d_obs() !== d_exp(a, 1, fill_line)) begin
      bad++; $display("FAIL dirty_data got=%h want=%h", d_obs(), d_exp(a, 1, fill_line));
    end
    total += 2;
    exp_arr[a[7:5]] = fill_line;
  endtask

  task automatic test_gaps();
    logic [31:0] a;
    logic [23:0] vt;
    int g;
    for (int n = 0; n < 2; n++) begin
      a = $urandom;
      vt = 24'($urandom);
      g = n == 0 ? 3 : int'($urandom_range(1, 4));
      run_fill(a, n == 0, vt, rnd_line(), g, 0);
      if (t_obs({a[31:5], 5'b0}, {vt, a[7:5], 5'b0}) !== t_exp(n == 0, g)) begin
        bad++; $display("FAIL gap_timing g=%0d got=%h want=%h", g, t_obs({a[31:5], 5'b0}, {vt, a[7:5], 5'b0}), t_exp(n == 0, g));
      end
      if (d_obs() !== d_exp(a, n == 0, fill_line)) begin
        bad++; $display("FAIL gap_data g=%0d got=%h want=%h", g, d_obs(), d_exp(a, n == 0, fill_line));
      end
      total += 2;
      exp_arr[a[7:5]] = fill_line;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a = $urandom;
    int hits = 0;
    fill_line = rnd_line();
    gap = 0;
    @(negedge clk);
    miss_req = 1;
    miss_addr = a;
    victim_dirty = 0;
    @(negedge clk);
    miss_req = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    if (outs() !== 389'd1) begin bad++; $display("FAIL midreset_outputs got=%h want=%h", outs(), 389'd1); end
    total++;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      hits += int'(line_load || fill_done || pmem_read || pmem_write);
    end
    if (hits !== 0) begin bad++; $display("FAIL midreset_activity got=%0d want=0", hits); end
    total++;
    a = $urandom;
    run_fill(a, 0, 24'($urandom), rnd_line(), 0, 0);
    if (t_obs({a[31:5], 5'b0}, 0) !== t_exp(0, 0)) begin
      bad++; $display("FAIL postreset_timing got=%h want=%h", t_obs({a[31:5], 5'b0}, 0), t_exp(0, 0));
    end
    if (d_obs() !== d_exp(a, 0, fill_line)) begin
      bad++; $display("FAIL postreset_data got=%h want=%h", d_obs(), d_exp(a, 0, fill_line));
    end
    total += 2;
    exp_arr[a[7:5]] = fill_line;
  endtask

  task automatic test_held();
    logic [31:0] a1 = $urandom, a2 = $urandom;
    logic [23:0] vt = 24'($urandom);
    stray = 1;
    run_fill(a1, 0, 24'($urandom), rnd_line(), 0, 1);
    if (t_obs({a1[31:5], 5'b0}, 0) !== t_exp(0, 0) || d_obs() !== d_exp(a1, 0, fill_line)) begin
      bad++; $display("FAIL held_first got=%h/%h want=%h/%h", t_obs({a1[31:5], 5'b0}, 0), d_obs(), t_exp(0, 0), d_exp(a1, 0, fill_line));
    end
    total++;
    exp_arr[a1[7:5]] = fill_line;
    run_fill(a2, 1, vt, rnd_line(), 1, 0);
    if (t_obs({a2[31:5], 5'b0}, {vt, a2[7:5], 5'b0}) !== t_exp(1, 1)) begin
      bad++; $display("FAIL held_second_timing got=%h want=%h", t_obs({a2[31:5], 5'b0}, {vt, a2[7:5], 5'b0}), t_exp(1, 1));
    end
    if (d_obs() !== d_exp(a2, 1, fill_line)) begin
      bad++; $display("FAIL held_second_data got=%h want=%h", d_obs(), d_exp(a2, 1, fill_line));
    end
    total += 2;
    exp_arr[a2[7:5]] = fill_line;
    stray = 0;
  endtask

  task automatic test_same_index();
    logic [31:0] a;
    logic [23:0] vt;
    for (int n = 0; n < 2; n++) begin
      a = {24'($urandom), 3'd5, 5'($urandom)};
      vt = 24'($urandom);
      run_fill(a, 1, vt, rnd_line(), 0, 0);
      if (t_obs({a[31:5], 5'b0}, {vt, 3'd5, 5'b0}) !== t_exp(1, 0)) begin
        bad++; $display("FAIL same_idx_timing n=%0d got=%h want=%h", n, t_obs({a[31:5], 5'b0}, {vt, 3'd5, 5'b0}), t_exp(1, 0));
      end
      if (d_obs() !== d_exp(a, 1, fill_line)) begin
        bad++; $display("FAIL same_idx_data n=%0d got=%h want=%h", n, d_obs(), d_exp(a, 1, fill_line));
      end
      total += 2;
      exp_arr[5] = fill_line;
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_dirty();
    test_gaps();
    test_reset_mid();
    test_held();
    test_same_index();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
